sound_sequencer: RTL



---
 rtl/sound_pkg.sv | 93 +++++++++
 rtl/melody_rom.sv | 15 +
 rtl/sound_sequencer.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/sound_pkg.sv
// Shared types and melody table for the sound sequencer.
// Event codes, FSM states, ROM entry layout, ROM base addresses,
// fixed-priority event selection and the melody ROM contents.
package sound_pkg;

  typedef enum logic [2:0] {
    EV_FWD   = 3'd0,
    EV_BACK  = 3'd1,
    EV_RIGHT = 3'd2,
    EV_LEFT  = 3'd3,
    EV_WIN   = 3'd4,
    EV_LOSE  = 3'd5,
    EV_NONE  = 3'd7
  } sndEvent_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_PLAY,
    ST_GAP
  } seqState_t;

  typedef struct packed {
    logic [15:0] period;
    logic [7:0]  dur;
  } romEntry_t;

  localparam int ROM_ADDR_W = 5;

  // Each melody is a run of notes terminated by a dur==0 entry.
  localparam logic [4:0] BASE_FWD   = 5'd0;
  localparam logic [4:0] BASE_BACK  = 5'd2;
  localparam logic [4:0] BASE_RIGHT = 5'd4;
  localparam logic [4:0] BASE_LEFT  = 5'd6;
  localparam logic [4:0] BASE_WIN   = 5'd8;
  localparam logic [4:0] BASE_LOSE  = 5'd13;

  // Pending-bit positions follow the event codes; bits 0..3 are the jumps.
  localparam logic [5:0] JUMP_MASK = 6'b001111;

  function automatic logic [4:0] baseAddr(input sndEvent_t ev);
    case (ev)
      EV_FWD:   return BASE_FWD;
      EV_BACK:  return BASE_BACK;
      EV_RIGHT: return BASE_RIGHT;
      EV_LEFT:  return BASE_LEFT;
      EV_WIN:   return BASE_WIN;
      EV_LOSE:  return BASE_LOSE;
      default:  return 5'd0;
    endcase
  endfunction

  // Preemption class: LOSE beats WIN beats any jump; jumps share a class.
  function automatic logic [1:0] eventClass(input sndEvent_t ev);
    case (ev)
      EV_LOSE: return 2'd2;
      EV_WIN:  return 2'd1;
      default: return 2'd0;
    endcase
  endfunction

  // Fixed priority LOSE > WIN > FWD > BACK > RIGHT > LEFT.
  function automatic sndEvent_t pickEvent(input logic [5:0] pend);
    if (pend[5])      return EV_LOSE;
    else if (pend[4]) return EV_WIN;
    else if (pend[0]) return EV_FWD;
    else if (pend[1]) return EV_BACK;
    else if (pend[2]) return EV_RIGHT;
    else if (pend[3]) return EV_LEFT;
    else              return EV_NONE;
  endfunction

  // Melody table: {half-period in clk cycles, duration in ticks}.
  function automatic romEntry_t romLookup(input logic [4:0] addr);
    romEntry_t e;
    case (addr)
      5'd0:    e = {16'd12000, 8'd40};
      5'd2:    e = {16'd14000, 8'd40};
      5'd4:    e = {16'd13000, 8'd30};
      5'd6:    e = {16'd13500, 8'd30};
      5'd8:    e = {16'd24000, 8'd100};
      5'd9:    e = {16'd19000, 8'd100};
      5'd10:   e = {16'd16000, 8'd100};
      5'd11:   e = {16'd12000, 8'd100};
      5'd13:   e = {16'd16000, 8'd150};
      5'd14:   e = {16'd20000, 8'd150};
      5'd15:   e = {16'd30000, 8'd150};
      default: e = {16'd0, 8'd0};
    endcase
    return e;
  endfunction

endpackage

// File: rtl/melody_rom.sv
// Melody ROM with a single-cycle registered read port.
module melody_rom
  import sound_pkg::*;
(
  input  logic                  clk,
  input  logic [ROM_ADDR_W-1:0] addr,
  output romEntry_t             data
);

  // Registered read: data holds the entry addressed on the previous edge.
  always_ff @(posedge clk) begin
    data <= romLookup(addr);
  end

endmodule

// File: rtl/sound_sequencer.sv
// Sound event sequencer: synchronizes and edge-detects game sound requests,
// arbitrates them by fixed priority and plays the selected melody note by
// note onto the square-wave tone generator.
// Build option: define SOUND_QUEUE_EN to keep non-preempting requests that
// arrive while busy pending (played afterwards); otherwise they are dropped.
module sound_sequencer
  import sound_pkg::*;
#(
  parameter int TICK_DIV  = 25175,
  parameter int GAP_TICKS = 10
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic        jump_forward,
  input  logic        jump_backward,
  input  logic        jump_right,
  input  logic        jump_left,
  input  logic        win,
  input  logic        lose,
  output logic [15:0] tone_period,
  output logic        tone_en,
  output logic        busy,
  output logic [2:0]  active_event,
  output logic        done
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_TICKS - 1);

  logic [5:0] reqRaw, syncP0, syncP1, syncP2, rise;
  logic [5:0] allowMask, clearMask, pending, pendingNext;
  seqState_t  state, nextState;
  sndEvent_t  curEvent, nextEvent, candidate;
  logic [3:0] noteIdx, nextIdx;
  logic [PRE_W-1:0] presc, nextPresc;
  logic [7:0] tickCnt, nextTick;
  logic       tickWrap, preempt, startNew, restart, doneNext;
  logic [4:0] romAddr;
  romEntry_t  romData;

  assign reqRaw = {lose, win, jump_left, jump_right, jump_backward, jump_forward};
  assign rise   = syncP1 & ~syncP2;

  // Two-flop synchronizer plus one history stage for rising-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      syncP0 <= '0;
      syncP1 <= '0;
      syncP2 <= '0;
    end else begin
      syncP0 <= reqRaw;
      syncP1 <= syncP0;
      syncP2 <= syncP1;
    end
  end

  // Which new edges may register as pending given what is currently playing.
  always_comb begin
    allowMask = '1;
`ifndef SOUND_QUEUE_EN
    if (state != ST_IDLE) begin
      case (eventClass(curEvent))
        2'd0:    allowMask = 6'b110000;
        2'd1:    allowMask = 6'b100000;
        default: allowMask = 6'b000000;
      endcase
    end
`endif
  end

  // Next-state, counter, pending and ROM-address logic.
  always_comb begin
    nextState = state;
    nextEvent = curEvent;
    nextIdx   = noteIdx;
    clearMask = '0;
    doneNext  = 1'b0;
    restart   = 1'b0;
    candidate = pickEvent(pending);
    tickWrap  = (presc == PRE_LAST);
    preempt   = (state != ST_IDLE) && (candidate != EV_NONE) &&
                (eventClass(candidate) > eventClass(curEvent));
    startNew  = preempt || ((state == ST_IDLE) && (candidate != EV_NONE));

    if (startNew) begin
      nextState = ST_LOAD;
      nextEvent = candidate;
      nextIdx   = 4'd0;
      restart   = 1'b1;
      clearMask = 6'b000001 << candidate;
      if (eventClass(candidate) != 2'd0) clearMask = clearMask | JUMP_MASK;
    end else begin
      case (state)
        ST_LOAD: begin
          restart = 1'b1;
          if (romData.dur == 8'd0) begin
            nextState = ST_IDLE;
            nextEvent = EV_NONE;
            doneNext  = 1'b1;
          end else begin
            nextState = ST_PLAY;
          end
        end
        ST_PLAY: begin
          if (tickWrap && (tickCnt == romData.dur - 8'd1)) begin
            nextState = ST_GAP;
            restart   = 1'b1;
          end
        end
        ST_GAP: begin
          if (tickWrap && (tickCnt == GAP_LAST)) begin
            nextState = ST_LOAD;
            nextIdx   = noteIdx + 4'd1;
            restart   = 1'b1;
          end
        end
        default: nextState = ST_IDLE;
      endcase
    end

    if (restart) begin
      nextPresc = '0;
      nextTick  = '0;
    end else if (tickWrap) begin
      nextPresc = '0;
      nextTick  = tickCnt + 8'd1;
    end else begin
      nextPresc = presc + 1'b1;
      nextTick  = tickCnt;
    end

    pendingNext = (pending | (rise & allowMask)) & ~clearMask;
    // Address from next-cycle event/index so the registered ROM is valid in LOAD.
    romAddr     = baseAddr(nextEvent) + {1'b0, nextIdx};
  end

  melody_rom uRom (
    .clk  (clk),
    .addr (romAddr),
    .data (romData)
  );

  // Sequencer state, counters and pending requests.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      curEvent <= EV_NONE;
      noteIdx  <= '0;
      presc    <= '0;
      tickCnt  <= '0;
      pending  <= '0;
    end else begin
      state    <= nextState;
      curEvent <= nextEvent;
      noteIdx  <= nextIdx;
      presc    <= nextPresc;
      tickCnt  <= nextTick;
      pending  <= pendingNext;
    end
  end

  // Registered outputs, computed from the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tone_period  <= '0;
      tone_en      <= 1'b0;
      busy         <= 1'b0;
      active_event <= EV_NONE;
      done         <= 1'b0;
    end else begin
      tone_period  <= (nextState == ST_PLAY) ? romData.period : 16'd0;
      tone_en      <= (nextState == ST_PLAY);
      busy         <= (nextState != ST_IDLE);
      active_event <= (nextState == ST_IDLE) ? EV_NONE : nextEvent;
      done         <= doneNext;
    end
  end

endmodule
